// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rr_arbiter
//  Description : Packet-locked round-robin arbiter that merges NUM_SRC
//                AXI-Stream inputs onto one registered AXI-Stream output.
//  Revision    : 1.0  initial release
// ============================================================================
module axis_rr_arbiter #(
  parameter  int NUM_SRC = 4,
  parameter  int DATA_W  = 32,
  parameter  int DEST_W  = 4,
  parameter  int USER_W  = 1,
  localparam int ID_W    = $clog2(NUM_SRC),
  localparam int KEEP_W  = DATA_W / 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  output logic [NUM_SRC-1:0]        s_tready,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0] s_tstrb,
  input  logic [NUM_SRC*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]        s_tlast,
  input  logic [NUM_SRC*DEST_W-1:0] s_tdest,
  input  logic [NUM_SRC*USER_W-1:0] s_tuser,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [KEEP_W-1:0]         m_tstrb,
  output logic [KEEP_W-1:0]         m_tkeep,
  output logic                      m_tlast,
  output logic [DEST_W-1:0]         m_tdest,
  output logic [USER_W-1:0]         m_tuser,
  output logic [ID_W-1:0]           m_tid,
  output logic                      grant_vld,
  output logic [ID_W-1:0]           grant_idx
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ID_W-1:0]   r_last;
  logic [ID_W-1:0]   r_grant_idx;
  logic              r_grant_vld;
  logic [ID_W-1:0]   w_sel_idx;
  logic              w_sel_vld;
  logic [31:0]       w_cand;
  logic              w_out_free;
  logic              w_accept;

  logic              r_m_tvalid;
  logic [DATA_W-1:0] r_m_tdata;
  logic [KEEP_W-1:0] r_m_tstrb;
  logic [KEEP_W-1:0] r_m_tkeep;
  logic              r_m_tlast;
  logic [DEST_W-1:0] r_m_tdest;
  logic [USER_W-1:0] r_m_tuser;
  logic [ID_W-1:0]   r_m_tid;

  logic [DATA_W-1:0] w_src_data [NUM_SRC];
  logic [KEEP_W-1:0] w_src_strb [NUM_SRC];
  logic [KEEP_W-1:0] w_src_keep [NUM_SRC];
  logic [DEST_W-1:0] w_src_dest [NUM_SRC];
  logic [USER_W-1:0] w_src_user [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign w_src_data[i] = s_tdata[i*DATA_W +: DATA_W];
    assign w_src_strb[i] = s_tstrb[i*KEEP_W +: KEEP_W];
    assign w_src_keep[i] = s_tkeep[i*KEEP_W +: KEEP_W];
    assign w_src_dest[i] = s_tdest[i*DEST_W +: DEST_W];
    assign w_src_user[i] = s_tuser[i*USER_W +: USER_W];
  end

  // Walk from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_cand = 32'(r_last) + 32'(k);
      if (w_cand >= 32'(NUM_SRC)) begin
        w_cand = w_cand - 32'(NUM_SRC);
      end
      if (s_tvalid[w_cand[ID_W-1:0]]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = w_cand[ID_W-1:0];
      end
    end
  end

  assign w_out_free = !r_m_tvalid || m_tready;
  assign w_accept   = (r_state == ST_BUSY) && s_tvalid[r_grant_idx] && w_out_free;

  always_comb begin
    s_tready = '0;
    if (r_state == ST_BUSY) begin
      s_tready[r_grant_idx] = w_out_free;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_vld) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_accept && s_tlast[r_grant_idx]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_last      <= ID_W'(NUM_SRC - 1);
      r_grant_idx <= '0;
      r_grant_vld <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_m_tdata   <= '0;
      r_m_tstrb   <= '0;
      r_m_tkeep   <= '0;
      r_m_tlast   <= 1'b0;
      r_m_tdest   <= '0;
      r_m_tuser   <= '0;
      r_m_tid     <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_sel_vld) begin
        r_grant_idx <= w_sel_idx;
        r_grant_vld <= 1'b1;
      end
      if (w_accept) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_src_data[r_grant_idx];
        r_m_tstrb  <= w_src_strb[r_grant_idx];
        r_m_tkeep  <= w_src_keep[r_grant_idx];
        r_m_tlast  <= s_tlast[r_grant_idx];
        r_m_tdest  <= w_src_dest[r_grant_idx];
        r_m_tuser  <= w_src_user[r_grant_idx];
        r_m_tid    <= r_grant_idx;
        // Packet done: release grant and advance the round-robin pointer.
        if (s_tlast[r_grant_idx]) begin
          r_last      <= r_grant_idx;
          r_grant_vld <= 1'b0;
        end
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign m_tvalid  = r_m_tvalid;
  assign m_tdata   = r_m_tdata;
  assign m_tstrb   = r_m_tstrb;
  assign m_tkeep   = r_m_tkeep;
  assign m_tlast   = r_m_tlast;
  assign m_tdest   = r_m_tdest;
  assign m_tuser   = r_m_tuser;
  assign m_tid     = r_m_tid;
  assign grant_vld = r_grant_vld;
  assign grant_idx = r_grant_idx;

endmodule
`default_nettype wire
